// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder, one full-adder cell, LSB first.
// Define SERIAL_ADD_SUB_EN to add the sub port (a - b via a + ~b + 1).
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] b_ld;
  logic [CW-1:0]    cnt;
  logic             cr;
  logic             cr_ld;
  logic             fa_s;
  logic             fa_c;

`ifdef SERIAL_ADD_SUB_EN
  assign b_ld  = sub ? ~b : b;
  assign cr_ld = sub | cin;
`else
  assign b_ld  = b;
  assign cr_ld = cin;
`endif

  assign fa_s = sa[0] ^ sb[0] ^ cr;
  assign fa_c = (sa[0] & sb[0])
              | (sa[0] & cr)
              | (sb[0] & cr);

  // new sum bit enters at the MSB
  assign acc_nxt = (acc >> 1)
                 | {fa_s, {(WIDTH-1){1'b0}}};

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      acc   <= '0;
      cr    <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= b_ld;
            cr    <= cr_ld;
            acc   <= '0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          acc <= acc_nxt;
          cr  <= fa_c;
          if (cnt == LAST) begin
            sum   <= acc_nxt;
            cout  <= fa_c;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: random and directed checks of serial_add_ctrl
// against an arithmetic reference; second instance at WIDTH=2.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  logic         start2 = 1'b0;
  logic [1:0]   a2 = '0;
  logic [1:0]   b2 = '0;
  logic         cin2 = 1'b0;
  logic         sub2 = 1'b0;
  logic         busy2;
  logic         done2;
  logic [1:0]   sum2;
  logic         cout2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  serial_add_ctrl #(.WIDTH(2)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start2),
    .a     (a2),
    .b     (b2),
    .cin   (cin2),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub2),
`endif
    .busy  (busy2),
    .done  (done2),
    .sum   (sum2),
    .cout  (cout2)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic op8(input logic [W-1:0] ta,
                     input logic [W-1:0] tbv,
                     input logic tc,
                     input logic ts,
                     input bit inj);
    logic [W:0] exp;
    int n;
    int nb;
    int nd;
    if (ts)
      exp = {1'b0, ta} + {1'b0, ~tbv} + 1;
    else
      exp = {1'b0, ta} + {1'b0, tbv} + (W+1)'(tc);
    @(negedge clk);
    a = ta; b = tbv; cin = tc; sub = ts;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a   = W'($urandom);
    b   = W'($urandom);
    cin = 1'($urandom);
    n = 0;
    nb = 0;
    while (!done && n < 40) begin
      if (busy) nb++;
      start = (inj && n == 3);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("latency", 64'(n), 64'(W));
    check("busy_cycles", 64'(nb), 64'(W));
    check("busy_in_done", 64'(busy), 64'd0);
    check("result", 64'({cout, sum}), 64'(exp));
    @(negedge clk);
    check("done_fall", 64'(done), 64'd0);
    if (inj) begin
      nd = 0;
      repeat (12) begin
        @(negedge clk);
        if (done || busy) nd++;
      end
      check("inj_no_extra", 64'(nd), 64'd0);
    end
  endtask

  initial begin
    logic [2:0] exp2;
    int n;
    int nd;
    logic rs;

    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    rst_n = 1'b1;

    op8(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    op8(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    op8(8'hA5, 8'h5A, 1'b1, 1'b0, 1'b0);
    op8(8'h3C, 8'h11, 1'b0, 1'b0, 1'b1);

    // abort by reset 4 edges after accept
    @(negedge clk);
    a = 8'h77; b = 8'h99; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_sum", 64'(sum), 64'd0);
    check("abort_cout", 64'(cout), 64'd0);
    nd = 0;
    repeat (12) begin
      if (done) nd++;
      @(negedge clk);
    end
    check("abort_no_done", 64'(nd), 64'd0);
    op8(8'h12, 8'h34, 1'b1, 1'b0, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
    op8(8'h10, 8'h01, 1'b0, 1'b1, 1'b0);
    op8(8'h01, 8'h02, 1'b1, 1'b1, 1'b0);
`endif

    for (int i = 0; i < 30; i++) begin
`ifdef SERIAL_ADD_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      op8(W'($urandom), W'($urandom),
          1'($urandom), rs, 1'b0);
    end

    // start held high: one result every W+2 cycles
    @(negedge clk);
    a = 8'h03; b = 8'h04; cin = 1'b0; sub = 1'b0;
    start = 1'b1;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("tput_first", 64'(done), 64'd1);
    n = 0;
    @(negedge clk);
    n++;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("tput_period", 64'(n), 64'(W + 2));
    check("tput_sum", 64'({cout, sum}), 64'h007);
    repeat (12) @(negedge clk);

    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      a2 = i[4:3]; b2 = i[2:1]; cin2 = i[0];
      exp2 = {1'b0, a2} + {1'b0, b2} + {2'b0, cin2};
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      a2 = 2'($urandom);
      b2 = 2'($urandom);
      n = 0;
      while (!done2 && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("w2_latency", 64'(n), 64'd2);
      check("w2_result", 64'({cout2, sum2}), 64'(exp2));
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial addition controller built around a single 1-bit full-adder cell. It accepts two WIDTH-bit operands and a carry-in through a start handshake. Over WIDTH cycles it feeds the operands LSB-first through the full adder, with the carry held in a register between cycles, and reports the registered sum and carry-out with a one-cycle done pulse. Use it in area-constrained datapaths in place of a WIDTH-bit ripple adder.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range 2..32
- clk  input  1  clock; all state changes on rising edge
- rst_n  input  1  synchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A; sampled on the accepting edge
- b  input  WIDTH  operand B; sampled on the accepting edge
- cin  input  1  carry-in; sampled on the accepting edge
- sub  input  1  subtract select; port exists only with SERIAL_ADD_SUB_EN
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse; result valid
- sum  output  WIDTH  registered result
- cout  output  1  registered carry-out of the MSB

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- **IDLE**
  - On start=1: load a and b into shift registers sa and sb, load cin into carry register cr, clear bit counter cnt, go to RUN.
  - With start=0: stay in IDLE.
- **RUN** (one bit per cycle)
  - The full adder computes s = sa[0]^sb[0]^cr and c = majority(sa[0], sb[0], cr).
  - sa and sb shift right by one.
  - s shifts into the MSB of the internal accumulator acc.
  - cr <= c.
  - cnt increments.
  - When cnt == WIDTH-1, this is the last bit. On that edge, sum <= the final acc value including this bit, cout <= c, and the FSM goes to DONE.
- **DONE**
  - done=1 for exactly one cycle, then the FSM goes to IDLE unconditionally.
  - start is ignored in DONE.
- start is ignored in RUN and DONE. No queueing; a request not accepted is lost.
- Operands are captured on the accepting edge. Changes to a, b or cin after that edge do not affect the result.
- sum and cout change only on the RUN→DONE edge. They hold until the next completion, including through IDLE and a new RUN.
- Arithmetic: {cout, sum} = a + b + cin, modulo 2^(WIDTH+1).
- cnt width is clog2(WIDTH). The counter does not wrap within one operation.

## Timing
- Reset (rst_n=0 at a rising edge): state=IDLE, busy=0, done=0, sum=0, cout=0, cnt=0, cr=0, sa/sb/acc=0.
- Reset wins over every other input on the same edge.
- Reset during RUN or DONE aborts the operation. No done pulse follows, and the result is discarded.
- Latency, with start accepted at edge E:
  - busy=1 from E through E+WIDTH.
  - At edge E+WIDTH, sum and cout update and done rises.
  - At edge E+WIDTH+1, done falls.
- The earliest next accept is edge E+WIDTH+2, i.e. start held high yields one result every WIDTH+2 cycles.
- busy and done are never high together.
- All outputs are registered or decoded directly from the state register, with no combinational path from inputs to outputs.

## Configuration
- SERIAL_ADD_SUB_EN defined:
  - The sub port exists and is sampled with the operands.
  - When sub=1, sb loads ~b and cr loads 1, so cin is ignored. The result is {cout, sum} = a + ~b + 1. cout=1 means no borrow (a ≥ b unsigned).
  - When sub=0, behaviour is identical to the macro-undefined case.
- SERIAL_ADD_SUB_EN undefined: the sub port is absent and the block is add-only.

## Test plan
All scenarios use WIDTH=8 unless stated otherwise.
- Reset, then a=0x00, b=0x00, cin=0, start for 1 cycle → busy for 8 cycles, done pulse at accept+8, sum=0x00, cout=0.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1.
- a=0xA5, b=0x5A, cin=1 → sum=0x00, cout=1.
- Second start pulse during RUN with different operands → ignored; first result correct; exactly one done pulse.
- Start accepted, rst_n=0 at accept+4 → busy=0, sum=0, cout=0, no done pulse; a new start then completes normally.
- SERIAL_ADD_SUB_EN builds:
  - sub=1, a=0x10, b=0x01 → sum=0x0F, cout=1.
  - sub=1, a=0x01, b=0x02 → sum=0xFF, cout=0.
- WIDTH=2: exhaustive over a, b and cin → {cout, sum} = a+b+cin for all 32 cases.
